// File: rtl/neuron_accumulator.sv
// Integrate stage for one 16-neuron group: scans input spikes, accumulates signed weight rows
// with saturation, then thresholds. Define ZERO_SKIP_EN to visit only the active spike rows.
module neuron_accumulator #(
    parameter int N_NEURON = 16,
    parameter int POT_W    = 8,
    parameter int N_INPUT  = 64,
    parameter int IDX_W    = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [POT_W-1:0]            threshold,
    input  logic [N_INPUT-1:0]          spk_vec_in,
    input  logic [N_NEURON*POT_W-1:0]   pot_in,
    output logic                        w_rd_en,
    output logic [IDX_W-1:0]            w_addr,
    input  logic [N_NEURON*POT_W-1:0]   w_data,
    output logic                        busy,
    output logic                        done,
    output logic [N_NEURON*POT_W-1:0]   pot_out,
    output logic [N_NEURON-1:0]         spk_out
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SCAN  = 3'd1,
        S_DRAIN = 3'd2,
        S_FIRE  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [N_INPUT-1:0]          spk_vec_q, spk_vec_d;
    logic [POT_W-1:0]            thr_q, thr_d;
    logic [N_NEURON*POT_W-1:0]   acc_q, acc_d;
    logic                        vld_q, vld_d;
    logic                        w_rd_en_q, w_rd_en_d;
    logic [IDX_W-1:0]            w_addr_q, w_addr_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic [N_NEURON*POT_W-1:0]   pot_out_q, pot_out_d;
    logic [N_NEURON-1:0]         spk_out_q, spk_out_d;
    logic                        accept_s;

    // 9-bit signed sum clamped to the 8-bit signed range
    function automatic logic [POT_W-1:0] sat_add(input logic [POT_W-1:0] a,
                                                  input logic [POT_W-1:0] b);
        logic [POT_W:0] s;
        s = {a[POT_W-1], a} + {b[POT_W-1], b};
        if (s[POT_W] != s[POT_W-1]) begin
            sat_add = s[POT_W] ? {1'b1, {(POT_W-1){1'b0}}} : {1'b0, {(POT_W-1){1'b1}}};
        end else begin
            sat_add = s[POT_W-1:0];
        end
    endfunction

`ifdef ZERO_SKIP_EN
    logic [N_INPUT-1:0] remain_s;

    function automatic logic [IDX_W-1:0] first_set(input logic [N_INPUT-1:0] m);
        first_set = {IDX_W{1'b0}};
        for (int i = N_INPUT - 1; i >= 0; i--) begin
            if (m[i]) begin
                first_set = IDX_W'(i);
            end
        end
    endfunction
`else
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_INPUT - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
`endif

    // A new timestep may begin from IDLE or directly from DONE
    assign accept_s = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            idx_q     <= {IDX_W{1'b0}};
            spk_vec_q <= {N_INPUT{1'b0}};
            thr_q     <= {POT_W{1'b0}};
            acc_q     <= {(N_NEURON*POT_W){1'b0}};
            vld_q     <= 1'b0;
            w_rd_en_q <= 1'b0;
            w_addr_q  <= {IDX_W{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pot_out_q <= {(N_NEURON*POT_W){1'b0}};
            spk_out_q <= {N_NEURON{1'b0}};
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            spk_vec_q <= spk_vec_d;
            thr_q     <= thr_d;
            acc_q     <= acc_d;
            vld_q     <= vld_d;
            w_rd_en_q <= w_rd_en_d;
            w_addr_q  <= w_addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pot_out_q <= pot_out_d;
            spk_out_q <= spk_out_d;
        end
    end

    // Next-state and scan index
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        spk_vec_d = spk_vec_q;
        thr_d     = thr_q;
`ifdef ZERO_SKIP_EN
        remain_s  = spk_vec_q & ~({{(N_INPUT-1){1'b0}}, 1'b1} << idx_q);
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    thr_d     = threshold;
                    spk_vec_d = spk_vec_in;
`ifdef ZERO_SKIP_EN
                    idx_d     = first_set(spk_vec_in);
                    state_d   = (|spk_vec_in) ? S_SCAN : S_DRAIN;
`else
                    idx_d     = {IDX_W{1'b0}};
                    state_d   = S_SCAN;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SCAN: begin
`ifdef ZERO_SKIP_EN
                // The remaining mask shrinks by the row just issued
                spk_vec_d = remain_s;
                if (|remain_s) begin
                    idx_d = first_set(remain_s);
                end else begin
                    state_d = S_DRAIN;
                end
`else
                if (idx_q == IDX_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
`endif
            end
            S_DRAIN: state_d = S_FIRE;
            S_FIRE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the upcoming state
    always_comb begin
        busy_d    = 1'b0;
        done_d    = 1'b0;
        w_rd_en_d = 1'b0;
        w_addr_d  = {IDX_W{1'b0}};
        case (state_d)
            S_SCAN: begin
                busy_d    = 1'b1;
                w_rd_en_d = spk_vec_d[idx_d];
                w_addr_d  = idx_d;
            end
            S_DRAIN, S_FIRE: busy_d = 1'b1;
            S_DONE:          done_d = 1'b1;
            default:         busy_d = 1'b0;
        endcase
    end

    // Accumulate one weight row per cycle; threshold and publish in FIRE
    always_comb begin
        vld_d     = w_rd_en_q;
        acc_d     = acc_q;
        pot_out_d = pot_out_q;
        spk_out_d = spk_out_q;
        if (accept_s) begin
            acc_d = pot_in;
        end else if (vld_q) begin
            for (int i = 0; i < N_NEURON; i++) begin
                acc_d[i*POT_W +: POT_W] = sat_add(acc_q[i*POT_W +: POT_W], w_data[i*POT_W +: POT_W]);
            end
        end else begin
            acc_d = acc_q;
        end
        if (state_q == S_FIRE) begin
            pot_out_d = acc_q;
            for (int i = 0; i < N_NEURON; i++) begin
                spk_out_d[i] = $signed(acc_q[i*POT_W +: POT_W]) >= $signed(thr_q);
            end
        end else begin
            pot_out_d = pot_out_q;
            spk_out_d = spk_out_q;
        end
    end

    assign w_rd_en = w_rd_en_q;
    assign w_addr  = w_addr_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pot_out = pot_out_q;
    assign spk_out = spk_out_q;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Randomized and directed bench for neuron_accumulator against an arithmetic reference model.
`timescale 1ns/1ps
module tb_neuron_accumulator;
    localparam int NN = 16;
    localparam int PW = 8;
    localparam int NI = 64;
    localparam int IW = 6;
    localparam int BW = NN * PW;
`ifdef ZERO_SKIP_EN
    localparam bit ZS = 1'b1;
`else
    localparam bit ZS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [PW-1:0] threshold;
    logic [NI-1:0] spk_vec_in;
    logic [BW-1:0] pot_in;
    logic          w_rd_en;
    logic [IW-1:0] w_addr;
    logic [BW-1:0] w_data;
    logic          busy;
    logic          done;
    logic [BW-1:0] pot_out;
    logic [NN-1:0] spk_out;

    neuron_accumulator #(.N_NEURON(NN), .POT_W(PW), .N_INPUT(NI), .IDX_W(IW)) dut (
        .clk(clk), .reset(reset), .start(start), .threshold(threshold),
        .spk_vec_in(spk_vec_in), .pot_in(pot_in), .w_rd_en(w_rd_en), .w_addr(w_addr),
        .w_data(w_data), .busy(busy), .done(done), .pot_out(pot_out), .spk_out(spk_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Weight RAM with one-cycle read latency; unread cycles carry junk
    logic [BW-1:0] w_mem [NI];
    logic          prev_rd = 1'b0;
    logic [IW-1:0] prev_addr = '0;
    always @(negedge clk) begin
        if (prev_rd) w_data = w_mem[prev_addr];
        else         w_data = {$urandom, $urandom, $urandom, $urandom};
        prev_rd   = w_rd_en;
        prev_addr = w_addr;
    end

    // Reference expectations for the current run (written only by the driver)
    int            S = 0, L = 0, run_id = 0, n_exp = 0;
    logic [BW-1:0] exp_pot = '0, prev_pot = '0, lit_pot = '0;
    logic [NN-1:0] exp_spk = '0, prev_spk = '0, lit_spk = '0;
    bit            lit_en = 1'b0;
    int            exp_rd_off [NI];
    int            exp_rd_addr[NI];

    int n_vec = 0, n_fail = 0, rd_ptr = 0, seen_id = 0;
    bit act_s;

    task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, required %h", nm, cyc, act, req);
        end
    endtask

    // Compare process: every cycle, DUT outputs against the model
    always @(negedge clk) begin
        if (run_id != seen_id) begin
            rd_ptr  = 0;
            seen_id = run_id;
        end
        act_s = (cyc >= S) && (cyc <= S + L - 1);
        if (act_s) begin
            chk("busy", BW'(busy), BW'(cyc <= S + L - 2));
            chk("done", BW'(done), BW'(cyc == S + L - 1));
            if (cyc == S + L - 1) begin
                chk("pot_out", pot_out, exp_pot);
                chk("spk_out", BW'(spk_out), BW'(exp_spk));
                chk("read_count", BW'(rd_ptr), BW'(n_exp));
                if (lit_en) begin
                    chk("lit_pot", pot_out, lit_pot);
                    chk("lit_spk", BW'(spk_out), BW'(lit_spk));
                end
            end else begin
                chk("pot_hold", pot_out, prev_pot);
                chk("spk_hold", BW'(spk_out), BW'(prev_spk));
            end
        end else begin
            chk("idle_busy", BW'(busy), '0);
            chk("idle_done", BW'(done), '0);
            chk("idle_pot", pot_out, exp_pot);
            chk("idle_spk", BW'(spk_out), BW'(exp_spk));
        end
        if (w_rd_en) begin
            if (!act_s || rd_ptr >= n_exp) begin
                n_vec++;
                n_fail++;
                $display("FAIL spurious_read at cycle %0d: got read of row %0d, required no read", cyc, w_addr);
            end else begin
                chk("read_cycle", BW'(cyc - S), BW'(exp_rd_off[rd_ptr]));
                chk("read_addr", BW'(w_addr), BW'(exp_rd_addr[rd_ptr]));
                rd_ptr++;
            end
        end
    end

    // Reference model: sequential saturating adds over the set spike rows, ascending
    task automatic model(input logic [PW-1:0] thr, input logic [NI-1:0] spk, input logic [BW-1:0] pot);
        logic signed [PW-1:0] v;
        int p, t;
        n_exp = 0;
        for (int b = 0; b < NI; b++) begin
            if (spk[b]) begin
                exp_rd_off[n_exp]  = ZS ? n_exp : b;
                exp_rd_addr[n_exp] = b;
                n_exp++;
            end
        end
        v = thr;
        t = int'(v);
        for (int n = 0; n < NN; n++) begin
            v = pot[n*PW +: PW];
            p = int'(v);
            for (int b = 0; b < NI; b++) begin
                if (spk[b]) begin
                    v = w_mem[b][n*PW +: PW];
                    p = p + int'(v);
                    if (p > 127)  p = 127;
                    if (p < -128) p = -128;
                end
            end
            exp_pot[n*PW +: PW] = p[PW-1:0];
            exp_spk[n]          = (p >= t);
        end
        L = ZS ? (n_exp + 3) : (NI + 3);
    endtask

    // Called at negedge+1 of a cycle in which the DUT is IDLE or DONE
    task automatic start_step(input logic [PW-1:0] thr, input logic [NI-1:0] spk, input logic [BW-1:0] pot,
                              input bit lit, input logic [BW-1:0] lp, input logic [NN-1:0] ls);
        threshold  = thr;
        spk_vec_in = spk;
        pot_in     = pot;
        start      = 1'b1;
        prev_pot   = exp_pot;
        prev_spk   = exp_spk;
        model(thr, spk, pot);
        S      = cyc + 1;
        lit_en = lit;
        lit_pot = lp;
        lit_spk = ls;
        run_id++;
        @(negedge clk); #1;
        start      = 1'b0;
        threshold  = PW'($urandom);
        spk_vec_in = {$urandom, $urandom};
        pot_in     = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_done();
        for (int k = 0; k < 300 && cyc < S + L - 1; k++) @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic rand_weights();
        for (int r = 0; r < NI; r++) w_mem[r] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; threshold = '0; spk_vec_in = '0; pot_in = '0;
        rand_weights();
        idle(3);
        reset = 1'b1;
        idle(2);

        // No spikes: potentials pass through untouched
        start_step(8'h40, 64'h0, {16{8'h10}}, 1'b1, {16{8'h10}}, 16'h0000);
        wait_done(); idle(1);

        // Single spike on row 5
        w_mem[5] = {16{8'h20}};
        start_step(8'h40, 64'h0000_0000_0000_0020, {16{8'h30}}, 1'b1, {16{8'h50}}, 16'hFFFF);
        wait_done(); idle(2);

        // Positive and negative saturation on rows 1 and 2
        w_mem[1] = {{14{8'h00}}, 8'hC0, 8'h40};
        w_mem[2] = {{14{8'h00}}, 8'hC0, 8'h40};
        start_step(8'h7F, 64'h0000_0000_0000_0006, {{14{8'h00}}, 8'h80, 8'h70},
                   1'b1, {{14{8'h00}}, 8'h80, 8'h7F}, 16'h0001);
        wait_done(); idle(1);

        // Reset asserted mid-scan aborts the timestep
        rand_weights();
        start_step(PW'($urandom), 64'hFFFF_0000_FFFF_0000, {$urandom, $urandom, $urandom, $urandom},
                   1'b0, '0, '0);
        idle(10);
        reset = 1'b0;
        S = 0; L = 0; n_exp = 0; exp_pot = '0; exp_spk = '0; prev_pot = '0; prev_spk = '0;
        run_id++;
        idle(3);
        reset = 1'b1;
        idle(2);

        // Two rows, far apart
        start_step(8'h00, 64'h1000_0000_0000_0008, {$urandom, $urandom, $urandom, $urandom},
                   1'b0, '0, '0);
        wait_done();

        // Back-to-back start in the DONE cycle, with a start pulse during busy ignored
        start_step(PW'($urandom), 64'h00FF_F0F0_0F0F_FF00, {$urandom, $urandom, $urandom, $urandom},
                   1'b0, '0, '0);
        idle(5);
        start = 1'b1; spk_vec_in = {$urandom, $urandom}; pot_in = {$urandom, $urandom, $urandom, $urandom};
        idle(1);
        start = 1'b0;
        wait_done();
        start_step(PW'($urandom), {$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                   1'b0, '0, '0);
        wait_done(); idle(1);

        // Randomized timesteps, alternating idle gaps and back-to-back starts
        for (int i = 0; i < 10; i++) begin
            rand_weights();
            start_step(PW'($urandom), {$urandom, $urandom} & {$urandom, $urandom},
                       {$urandom, $urandom, $urandom, $urandom}, 1'b0, '0, '0);
            wait_done();
            if (i % 2 == 0) idle(2);
        end

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron_accumulator.md
Name: neuron_accumulator

Overview:
- Integrate stage for one 16-neuron group per timestep.
- Takes the beta-decayed potentials produced by the load path of the potential processor.
- Adds the synaptic weight rows of every active input spike, with saturation, then thresholds.
- Emits 16 potentials and 16 spike bits that feed the save path, which zeroes the potentials of neurons that spiked.

Parameters:
- N_NEURON, 16, neurons per group (fixes 128-bit potential and weight buses at POT_W=8).
- POT_W, 8, potential and weight width, signed two's complement.
- N_INPUT, 64, input spike lines scanned per timestep.
- IDX_W, 6, width of the weight row address (clog2 of N_INPUT).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a timestep; sampled only when busy=0.
- threshold  in  8  signed firing threshold; sampled at start.
- spk_vec_in  in  N_INPUT  input spike bits; sampled at start.
- pot_in  in  128  16x8 decayed potentials; neuron i is at [8i+7:8i]; sampled at start.
- w_rd_en  out  1  weight row read strobe.
- w_addr  out  IDX_W  weight row index (= input spike index).
- w_data  in  128  16x8 signed weights; valid the cycle after w_rd_en.
- busy  out  1  timestep in progress.
- done  out  1  one-cycle pulse; pot_out and spk_out are valid.
- pot_out  out  128  accumulated potentials; drives save_16n_potential_in.
- spk_out  out  16  spike bits; drives save_16n_spk_in.

Behaviour:
- Reset (asynchronous, active-low): all outputs are 0, FSM goes to IDLE, accumulators are 0.
- Reset asserted mid-operation aborts the timestep. No done pulse is issued and the outputs clear.
- FSM states: IDLE, SCAN, DRAIN, FIRE, DONE.
- IDLE: busy=0. On start=1:
  - Latch spk_vec_in, threshold, and pot_in into the 16 accumulators.
  - Set idx=0 and go to SCAN.
- SCAN: busy=1, one index per cycle.
  - w_addr=idx.
  - w_rd_en = spk_vec[idx].
  - When idx=N_INPUT-1, go to DRAIN; otherwise idx increments.
- Read pipeline:
  - A registered flag marks that w_data is valid in the cycle after w_rd_en.
  - In that cycle each acc[i] <= sat(acc[i] + w_data[i]).
  - This gives one accumulate per cycle with no stalls.
- Saturation: the sum is computed at 9 bits signed and clamped to [-128 (0x80), +127 (0x7F)].
- DRAIN: busy=1, w_rd_en=0. The last pending row is absorbed. Go to FIRE.
- FIRE: busy=1.
  - spk_out[i] <= (acc[i] >= threshold), signed compare.
  - pot_out <= acc (raw value; zeroing on spike belongs to the save stage).
  - Go to DONE.
- DONE:
  - done=1 and busy=0. Go to IDLE.
  - start in this cycle is accepted as in IDLE, allowing back-to-back timesteps.
- Output hold: pot_out and spk_out hold their values until the next FIRE or reset.
- Latency: start sampled in cycle 0 gives done in cycle N_INPUT+3 (67 at default).
- start asserted while busy=1 is ignored.
- spk_vec all zero: no reads are issued, pot_out = pot_in, latency is unchanged.
- Weights and threshold are signed, so negative weights inhibit.

Optional Feature:
- Macro: ZERO_SKIP_EN.
- When defined, SCAN jumps directly to the next set bit each cycle using a priority encoder on the remaining spike mask:
  - Only active rows are visited.
  - With zero set bits, IDLE goes straight to DRAIN.
  - Latency = popcount(spk_vec)+3.
- When undefined, the scan visits all N_INPUT indices with fixed latency N_INPUT+3.
- Arithmetic results are identical in both modes.

Test Plan:
- Reset: hold reset low mid-SCAN, release -> busy=0, done=0, pot_out=0, spk_out=0, w_rd_en=0. The next start runs normally.
- No spikes: pot_in all 0x10, threshold 0x40, spk_vec=0 -> done at cycle 67, pot_out all 0x10, spk_out=0x0000, zero reads issued.
- Single spike: spk_vec bit 5 set, weight row 5 all 0x20, pot_in all 0x30, threshold 0x40:
  - Exactly one read with w_addr=5.
  - pot_out all 0x50, spk_out=0xFFFF.
- Saturation and inhibition: bits 1 and 2 set.
  - Rows: neuron0 +0x40, +0x40 with pot 0x70 -> 0x7F.
  - Neuron1: 0xC0, 0xC0 with pot 0x80 -> 0x80.
  - Threshold 0x7F -> spk_out bit0=1, bit1=0.
- Back-to-back: assert start in the DONE cycle with new data -> second done exactly 67 cycles later. A start pulse during busy has no effect.
- ZERO_SKIP_EN build: spikes at bits 3 and 60 -> reads at w_addr 3 then 60 on consecutive cycles, done at cycle 5. With spk_vec=0, done at cycle 3.
